mul_accum_stage: RTL and testbench
==================================

MUL_ACCUM_STAGE -- requirements
Module: mul_accum_stage

Interface
REQ-001 SHALL have parameter PW, default 128, product/accumulator width in bits.
REQ-002 SHALL have parameter CW, default 16, beat-counter width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  product beat valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-007 SHALL have port in_prod  input  PW  product from the 64x64 multiplier.
REQ-008 SHALL have port in_signed  input  1  1 = two's-complement product, 0 = unsigned.
REQ-009 SHALL have port in_last  input  1  final beat of the current accumulation.
REQ-010 SHALL have port out_valid  output  1  accumulated result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_acc  output  PW  accumulated sum.
REQ-013 SHALL have port out_count  output  CW  number of beats accumulated.
REQ-014 SHALL have port out_ovf  output  1  sticky overflow flag for this accumulation.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, HOLD; a beat is accepted when in_valid && in_ready.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACC, 0 in HOLD.
REQ-017 IDLE: on an accepted beat, acc <= in_prod, count <= 1, mode <= in_signed, ovf <= 0; next state ACC, or HOLD if in_last.
REQ-018 ACC: on an accepted beat, acc <= acc + in_prod (PW-bit), count += 1; next state HOLD if in_last, else ACC.
REQ-019 SHALL latch signed mode on the first beat only; in_signed on later beats of the same accumulation is ignored.
REQ-020 Overflow SHALL be detected per beat: signed mode -> both operand MSBs equal and sum MSB differs; unsigned mode -> carry out of bit PW-1; ovf is sticky until the next IDLE-accepted beat.
REQ-021 count SHALL saturate at 2^CW-1; further beats still accumulate.
REQ-022 HOLD: out_valid = 1, out_acc/out_count/out_ovf stable; on out_ready go to IDLE; out_valid stays 1 until accepted.
REQ-023 out_valid SHALL be 0 in IDLE and ACC; out_acc/out_count/out_ovf hold their last values outside HOLD.
REQ-024 Latency: beat with in_last accepted at edge N -> out_valid = 1 after edge N; earliest next beat accepted at edge after out_ready handshake (no same-cycle hand-over).
REQ-025 in_valid without in_ready SHALL have no effect; in_prod is sampled only on accepted beats.

Reset
REQ-026 When reset = 0 at a rising clk edge, SHALL go to IDLE with acc = 0, count = 0, ovf = 0, mode = 0, out_valid = 0; in_ready = 1 in the cycle after.
REQ-027 Reset mid-accumulation or in HOLD SHALL discard the partial/pending result without producing out_valid.

Configuration
REQ-028 Macro MUL_ACCUM_SAT_EN defined: on overflow acc SHALL saturate (signed: 0x7FF..F / 0x800..0 by sign of operands; unsigned: all ones) and remain saturated-capable on later beats; ovf still set.
REQ-029 Macro MUL_ACCUM_SAT_EN undefined: acc SHALL wrap modulo 2^PW; ovf still set.

Verification
REQ-030 Unsigned 3 beats 5, 7, 9 (last on 9) -> out_acc = 21, out_count = 3, out_ovf = 0, out_valid one cycle after third beat.
REQ-031 Signed beats -6 (0xFF..FA), 4 -> out_acc = 0xFF..FE (-2), out_ovf = 0; in_signed toggled to 0 on beat 2 has no effect.
REQ-032 Unsigned beats 0xFF..FF, 2 -> wrap build: out_acc = 1, out_ovf = 1; SAT build: out_acc = 0xFF..FF, out_ovf = 1.
REQ-033 Signed beats 0x7FF..FF, 1 -> wrap build: out_acc = 0x800..00, out_ovf = 1; SAT build: out_acc = 0x7FF..FF.
REQ-034 Hold out_ready = 0 for 5 cycles in HOLD with in_valid = 1 -> in_ready = 0, out_acc stable, no beat accepted; release -> IDLE, next beat starts fresh sum.
REQ-035 Assert reset = 0 after 2 of 4 beats -> out_valid never asserts, next accumulation 10 (last) -> out_acc = 10, out_count = 1.

Source files
------------

// File: rtl/mul_accum_stage.sv
// Multiply-accumulate output stage: sums product beats into a PW-bit accumulator and presents the total with a beat count and a sticky overflow flag.
// Latency: the result is valid one cycle after the last beat. Backpressure: in_ready drops while a result waits for out_ready. MUL_ACCUM_SAT_EN selects saturating accumulation.
module mul_accum_stage #(
    parameter int PW = 128,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_signed,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_acc,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0] acc;
    logic [CW-1:0] count;
    logic          mode;
    logic          ovf;

    logic [PW-1:0] res_acc;
    logic [CW-1:0] res_count;
    logic          res_ovf;

    logic          accept;
    logic [PW:0]   sum_ext;
    logic [PW-1:0] sum;
    logic          beat_ovf;
    logic [PW-1:0] sat_val;
    logic [PW-1:0] acc_add;
    logic [CW-1:0] count_inc;

    logic [PW-1:0] acc_nxt;
    logic [CW-1:0] count_nxt;
    logic          mode_nxt;
    logic          ovf_nxt;

    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc} + {1'b0, in_prod};
    assign sum     = sum_ext[PW-1:0];

    // Signed overflow: like-signed operands yielding a result of the other sign.
    assign beat_ovf = mode ? ((acc[PW-1] == in_prod[PW-1]) && (sum[PW-1] != acc[PW-1]))
                           : sum_ext[PW];

    assign sat_val = mode ? (acc[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}})
                          : {PW{1'b1}};

`ifdef MUL_ACCUM_SAT_EN
    assign acc_add = beat_ovf ? sat_val : sum;
`else
    assign acc_add = sum;
`endif

    assign count_inc = (&count) ? count : count + 1'b1;

    // First beat of an accumulation restarts the sum, count, mode and flag.
    always_comb begin
        acc_nxt   = acc_add;
        count_nxt = count_inc;
        mode_nxt  = mode;
        ovf_nxt   = ovf | beat_ovf;
        if (state == IDLE) begin
            acc_nxt   = in_prod;
            count_nxt = {{(CW-1){1'b0}}, 1'b1};
            mode_nxt  = in_signed;
            ovf_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            count     <= '0;
            mode      <= 1'b0;
            ovf       <= 1'b0;
            res_acc   <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            mode  <= mode_nxt;
            ovf   <= ovf_nxt;
            // Result registers only change on the closing beat so they stay put outside HOLD.
            if (in_last) begin
                res_acc   <= acc_nxt;
                res_count <= count_nxt;
                res_ovf   <= ovf_nxt;
            end
        end
    end

    assign out_acc   = res_acc;
    assign out_count = res_count;
    assign out_ovf   = res_ovf;

endmodule

// File: tb/tb_mul_accum_stage.sv
// Scoreboard bench for mul_accum_stage: a range-checking arithmetic model queues expected results, a monitor pops them on each output handshake.
module tb_mul_accum_stage;

    localparam int PW = 128;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [PW-1:0] acc;
        logic [CW-1:0] count;
        logic          ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_prod = '0;
    logic          in_signed = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_acc;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    int tests = 0;
    int fails = 0;
    bit rdy_rand = 1'b1;

    res_t exp_q[$];

    logic [PW-1:0] m_acc;
    int            m_cnt;
    logic          m_mode;
    logic          m_ovf;
    bit            m_active = 1'b0;

    localparam logic [PW-1:0] ALL1 = {PW{1'b1}};
    localparam logic [PW-1:0] SMAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] SMIN = {1'b1, {(PW-1){1'b0}}};

    mul_accum_stage #(.PW(PW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_signed (in_signed),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: exact sum in a wider integer, then range-checked against the PW-bit domain.
    task automatic model_beat(input logic [PW-1:0] p, input logic s, input logic last);
        logic signed [PW+1:0] a_s, b_s, t_s;
        logic [PW+1:0]        t_u;
        res_t                 r;
        if (!m_active) begin
            m_acc = p; m_cnt = 1; m_mode = s; m_ovf = 1'b0; m_active = 1'b1;
        end else begin
            m_cnt++;
            if (m_mode) begin
                a_s = $signed({{2{m_acc[PW-1]}}, m_acc});
                b_s = $signed({{2{p[PW-1]}}, p});
                t_s = a_s + b_s;
                m_acc = t_s[PW-1:0];
                if (t_s > $signed({2'b00, SMAX})) begin
                    m_ovf = 1'b1;
`ifdef MUL_ACCUM_SAT_EN
                    m_acc = SMAX;
`endif
                end else if (t_s < $signed({2'b11, SMIN})) begin
                    m_ovf = 1'b1;
`ifdef MUL_ACCUM_SAT_EN
                    m_acc = SMIN;
`endif
                end
            end else begin
                t_u = {2'b00, m_acc} + {2'b00, p};
                m_acc = t_u[PW-1:0];
                if (t_u > {2'b00, ALL1}) begin
                    m_ovf = 1'b1;
`ifdef MUL_ACCUM_SAT_EN
                    m_acc = ALL1;
`endif
                end
            end
        end
        if (last) begin
            r.acc = m_acc;
            r.count = CW'((m_cnt > CMAX) ? CMAX : m_cnt);
            r.ovf = m_ovf;
            exp_q.push_back(r);
            m_active = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [PW-1:0] p, input logic s, input logic last);
        int n;
        in_valid = 1'b1; in_prod = p; in_signed = s; in_last = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0 for %0d cycles", n);
        end
        @(posedge clk);
        model_beat(p, s, last);
        #1;
        in_valid = 1'b0;
        if (last) check("latency_out_valid", PW'(out_valid), PW'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [PW-1:0] rand_prod();
        logic [PW-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 4))
            0: rand_prod = PW'($urandom_range(0, 1000));
            1: rand_prod = ALL1 - PW'($urandom_range(0, 1000));
            2: rand_prod = SMAX - PW'($urandom_range(0, 1000));
            3: rand_prod = SMIN + PW'($urandom_range(0, 1000));
            default: rand_prod = r;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
    end

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (reset && out_valid) begin
            if (in_ready) begin
                tests++; fails++;
                $display("FAIL ready_in_hold: in_ready=1 while out_valid=1");
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: acc=0x%0h count=%0d with no result expected", out_acc, out_count);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_acc", out_acc, e.acc);
                    check("sb_count", PW'(out_count), PW'(e.count));
                    check("sb_ovf", PW'(out_ovf), PW'(e.ovf));
                end
            end
        end
    end

    initial begin
        int nb;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("reset_in_ready", PW'(in_ready), PW'(1));
        check("reset_out_valid", PW'(out_valid), PW'(0));
        check("reset_out_acc", out_acc, '0);
        check("reset_out_count", PW'(out_count), '0);
        check("reset_out_ovf", PW'(out_ovf), '0);

        send_beat(PW'(5), 1'b0, 1'b0);
        send_beat(PW'(7), 1'b0, 1'b0);
        send_beat(PW'(9), 1'b0, 1'b1);
        check("unsigned3_acc", out_acc, PW'(21));
        check("unsigned3_count", PW'(out_count), PW'(3));
        check("unsigned3_ovf", PW'(out_ovf), PW'(0));

        send_beat(ALL1 - PW'(5), 1'b1, 1'b0);
        send_beat(PW'(4), 1'b0, 1'b1);
        check("signed_neg_acc", out_acc, ALL1 - PW'(1));
        check("signed_neg_ovf", PW'(out_ovf), PW'(0));

        send_beat(ALL1, 1'b0, 1'b0);
        send_beat(PW'(2), 1'b0, 1'b1);
`ifdef MUL_ACCUM_SAT_EN
        check("uovf_acc", out_acc, ALL1);
`else
        check("uovf_acc", out_acc, PW'(1));
`endif
        check("uovf_flag", PW'(out_ovf), PW'(1));

        send_beat(SMAX, 1'b1, 1'b0);
        send_beat(PW'(1), 1'b1, 1'b1);
`ifdef MUL_ACCUM_SAT_EN
        check("sovf_acc", out_acc, SMAX);
`else
        check("sovf_acc", out_acc, SMIN);
`endif
        check("sovf_flag", PW'(out_ovf), PW'(1));

        drain();
        rdy_rand = 1'b0;
        out_ready = 1'b0;
        send_beat(PW'(3), 1'b0, 1'b0);
        send_beat(PW'(4), 1'b0, 1'b1);
        in_valid = 1'b1; in_prod = PW'(99); in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", PW'(in_ready), PW'(0));
            check("hold_out_valid", PW'(out_valid), PW'(1));
            check("hold_out_acc", out_acc, PW'(7));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rdy_rand = 1'b1;
        send_beat(PW'(5), 1'b0, 1'b1);
        check("fresh_after_hold", out_acc, PW'(5));

        drain();
        send_beat(PW'(3), 1'b0, 1'b0);
        send_beat(PW'(4), 1'b0, 1'b0);
        reset = 1'b0;
        m_active = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("midreset_in_ready", PW'(in_ready), PW'(1));
        check("midreset_out_valid", PW'(out_valid), PW'(0));
        send_beat(PW'(10), 1'b0, 1'b1);
        check("after_reset_acc", out_acc, PW'(10));
        check("after_reset_count", PW'(out_count), PW'(1));

        for (int k = 0; k < 40; k++) begin
            nb = ($urandom_range(0, 7) == 0) ? 18 : $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                send_beat(rand_prod(), 1'($urandom_range(0, 1)), b == nb - 1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
